shiftreg_ctrl: RTL and testbench

SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

---
 rtl/shiftreg_ctrl_if.sv | 27 ++
 rtl/shiftreg_ctrl.sv | 129 ++++++++++++
 tb/tb_shiftreg_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_ctrl_if.sv
// shiftreg_ctrl_if: request/response handshake and external shift-register bus of shiftreg_ctrl.
interface shiftreg_ctrl_if #(
    parameter int WIDTH = 24
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] req_data_i;
    logic             sr_din_o;
    logic             sr_shift_en_o;
    logic             sr_latch_o;
    logic [WIDTH-1:0] dout_parallel_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic             abort_i;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_data_i, dout_parallel_i, rsp_ready_i, abort_i,
        output req_ready_o, sr_din_o, sr_shift_en_o, sr_latch_o, rsp_valid_o, rsp_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, dout_parallel_i, rsp_ready_i, abort_i,
        input  req_ready_o, sr_din_o, sr_shift_en_o, sr_latch_o, rsp_valid_o, rsp_data_o, busy_o
    );
endinterface

// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: serialises a word into an external shift register, latches it and captures the parallel readback.
// Define SHIFTREG_CTRL_MSB_FIRST_EN to shift MSB first; LSB first otherwise.
module shiftreg_ctrl #(
    parameter int WIDTH = 24,
    parameter int DIV   = 1
) (
    input logic            clk,
    input logic            reset_ni,
    shiftreg_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [7:0] SLOT_LAST = 8'(DIV - 1);
    localparam logic [6:0] BIT_LAST  = 7'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [7:0]       slot_q, slot_d;
    logic [6:0]       bit_q, bit_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             din_q, din_d;
    logic             shift_en_q, shift_en_d;
    logic             latch_q, latch_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             first_bit, next_bit;
    logic [6:0]       next_idx;

`ifdef SHIFTREG_CTRL_MSB_FIRST_EN
    assign first_bit = bus.req_data_i[WIDTH-1];
    assign next_idx  = BIT_LAST - 7'd1 - bit_q;
`else
    assign first_bit = bus.req_data_i[0];
    assign next_idx  = bit_q + 7'd1;
`endif
    assign next_bit = |(shadow_q & (ONE << next_idx));

    // Strobes are registered: each is prepared on the edge that opens its cycle.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bit_d       = bit_q;
        shadow_d    = shadow_q;
        din_d       = din_q;
        shift_en_d  = 1'b0;
        latch_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: if (bus.req_valid_i) begin
                state_d    = S_SHIFT;
                shadow_d   = bus.req_data_i;
                din_d      = first_bit;
                shift_en_d = 1'b1;
                slot_d     = 8'd0;
                bit_d      = 7'd0;
            end
            S_SHIFT: if (slot_q == SLOT_LAST) begin
                slot_d = 8'd0;
                if (bit_q == BIT_LAST) begin
                    bit_d   = 7'd0;
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                end else begin
                    bit_d      = bit_q + 7'd1;
                    din_d      = next_bit;
                    shift_en_d = 1'b1;
                end
            end else begin
                slot_d = slot_q + 8'd1;
            end
            S_LATCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                state_d     = S_RESP;
                rsp_data_d  = bus.dout_parallel_i;
                rsp_valid_d = 1'b1;
            end
            S_RESP: if (bus.rsp_ready_i) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort_i && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            slot_d      = 8'd0;
            bit_d       = 7'd0;
            shift_en_d  = 1'b0;
            latch_d     = 1'b0;
            rsp_valid_d = 1'b0;
            rsp_data_d  = rsp_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            slot_q      <= 8'd0;
            bit_q       <= 7'd0;
            shadow_q    <= '0;
            rsp_data_q  <= '0;
            din_q       <= 1'b0;
            shift_en_q  <= 1'b0;
            latch_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bit_q       <= bit_d;
            shadow_q    <= shadow_d;
            rsp_data_q  <= rsp_data_d;
            din_q       <= din_d;
            shift_en_q  <= shift_en_d;
            latch_q     <= latch_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready_o   = state_q == S_IDLE;
    assign bus.busy_o        = state_q != S_IDLE;
    assign bus.sr_din_o      = din_q;
    assign bus.sr_shift_en_o = shift_en_q;
    assign bus.sr_latch_o    = latch_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_data_o    = rsp_data_q;
endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb_shiftreg_ctrl: directed scoreboard bench for shiftreg_ctrl (24-bit/DIV=1 and 8-bit/DIV=3 instances).
module tb_shiftreg_ctrl;
    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    shiftreg_ctrl_if #(.WIDTH(24)) if0();
    shiftreg_ctrl_if #(.WIDTH(8))  if1();

    shiftreg_ctrl #(.WIDTH(24), .DIV(1)) u0 (.clk(clk), .reset_ni(reset_ni), .bus(if0));
    shiftreg_ctrl #(.WIDTH(8),  .DIV(3)) u1 (.clk(clk), .reset_ni(reset_ni), .bus(if1));

    int total = 0;
    int bad = 0;
    logic [23:0] q0[$];
    logic [7:0]  q1[$];

    // Behavioural external shift register with output latch, one per DUT.
    logic [23:0] sr0, par0;
    logic [7:0]  sr1, par1;
    always @(posedge clk) begin
`ifdef SHIFTREG_CTRL_MSB_FIRST_EN
        if (if0.sr_shift_en_o) sr0 <= {sr0[22:0], if0.sr_din_o};
        if (if1.sr_shift_en_o) sr1 <= {sr1[6:0], if1.sr_din_o};
`else
        if (if0.sr_shift_en_o) sr0 <= {if0.sr_din_o, sr0[23:1]};
        if (if1.sr_shift_en_o) sr1 <= {if1.sr_din_o, sr1[7:1]};
`endif
        if (if0.sr_latch_o) par0 <= sr0;
        if (if1.sr_latch_o) par1 <= sr1;
    end
    assign if0.dout_parallel_i = par0;
    assign if1.dout_parallel_i = par1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] order24(input logic [23:0] d);
        logic [23:0] r;
`ifdef SHIFTREG_CTRL_MSB_FIRST_EN
        r = {<<{d}};
`else
        r = d;
`endif
        return r;
    endfunction

    // Scoreboard monitors: a response is delivered on valid && ready without abort.
    always @(negedge clk) begin
        if (reset_ni && if0.rsp_valid_o && if0.rsp_ready_i && !if0.abort_i) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL sb0_unexpected: got %0h expected no response", if0.rsp_data_o);
            end else chk("sb0_data", 64'(if0.rsp_data_o), 64'(q0.pop_front()));
        end
        if (reset_ni && if1.rsp_valid_o && if1.rsp_ready_i && !if1.abort_i) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL sb1_unexpected: got %0h expected no response", if1.rsp_data_o);
            end else chk("sb1_data", 64'(if1.rsp_data_o), 64'(q1.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start0(input logic [23:0] d);
        if0.req_valid_i = 1'b1;
        if0.req_data_i  = d;
        @(negedge clk);
        chk("req_ready0", 64'(if0.req_ready_o), 64'd1);
        tick();
        if0.req_valid_i = 1'b0;
    endtask

    task automatic obs0(input int n, output int ns, output int lc, output int vc, output logic [23:0] seq);
        ns = 0; lc = 0; vc = 0; seq = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (if0.sr_shift_en_o) begin
                seq = {if0.sr_din_o, seq[23:1]};
                ns++;
            end
            if (if0.sr_latch_o && lc == 0) lc = c;
            if (if0.rsp_valid_o && vc == 0) vc = c;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still going at 100000, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, lc, vc, vc2, ah, rh, late, anyl, anyv, bad_st, bad_din, early, unstable;
        logic [23:0] seq;
        if0.req_valid_i = 1'b0; if0.req_data_i = '0; if0.rsp_ready_i = 1'b1; if0.abort_i = 1'b0;
        if1.req_valid_i = 1'b0; if1.req_data_i = '0; if1.rsp_ready_i = 1'b1; if1.abort_i = 1'b0;
        sr0 = '0; par0 = '0; sr1 = '0; par1 = '0;
        #22;
        chk("rst_busy",     64'(if0.busy_o),        64'd0);
        chk("rst_ready",    64'(if0.req_ready_o),   64'd1);
        chk("rst_shift_en", 64'(if0.sr_shift_en_o), 64'd0);
        chk("rst_latch",    64'(if0.sr_latch_o),    64'd0);
        chk("rst_valid",    64'(if0.rsp_valid_o),   64'd0);
        chk("rst_rsp_data", 64'(if0.rsp_data_o),    64'd0);
        @(negedge clk) reset_ni = 1'b1;
        tick();

        // Basic 24-bit transfer
        q0.push_back(24'hA5C3F0);
        start0(24'hA5C3F0);
        obs0(30, ns, lc, vc, seq);
        chk("t1_strobes", 64'(ns), 64'd24);
        chk("t1_latch_cyc", 64'(lc), 64'd25);
        chk("t1_valid_cyc", 64'(vc), 64'd27);
        chk("t1_bit_order", 64'(seq), 64'(order24(24'hA5C3F0)));

        // 8-bit, DIV=3: 8'h81 is palindromic so bit sequence is 1,0,0,0,0,0,0,1 either way
        q1.push_back(8'h81);
        if1.req_valid_i = 1'b1; if1.req_data_i = 8'h81;
        @(negedge clk);
        chk("t2_ready", 64'(if1.req_ready_o), 64'd1);
        tick();
        if1.req_valid_i = 1'b0;
        ns = 0; lc = 0; vc = 0; bad_st = 0; bad_din = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (if1.sr_shift_en_o) ns++;
            if (if1.sr_shift_en_o !== (c <= 24 && (c - 1) % 3 == 0)) bad_st++;
            if (c <= 24 && if1.sr_din_o !== ((c - 1) / 3 == 0 || (c - 1) / 3 == 7)) bad_din++;
            if (if1.sr_latch_o && lc == 0) lc = c;
            if (if1.rsp_valid_o && vc == 0) vc = c;
            tick();
        end
        chk("t2_strobes", 64'(ns), 64'd8);
        chk("t2_strobe_slots", 64'(bad_st), 64'd0);
        chk("t2_din_stable", 64'(bad_din), 64'd0);
        chk("t2_latch_cyc", 64'(lc), 64'd25);
        chk("t2_valid_cyc", 64'(vc), 64'd27);

        // Abort in cycle 10
        start0(24'h123456);
        late = 0; anyl = 0; anyv = 0; ns = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) if0.abort_i = 1'b1;
            if (c == 11) if0.abort_i = 1'b0;
            @(negedge clk);
            if (if0.sr_shift_en_o) begin if (c >= 11) late++; else ns++; end
            if (if0.sr_latch_o) anyl++;
            if (if0.rsp_valid_o) anyv++;
            if (c == 11) begin
                chk("t3_ready_c11", 64'(if0.req_ready_o), 64'd1);
                chk("t3_busy_c11", 64'(if0.busy_o), 64'd0);
            end
            tick();
        end
        chk("t3_strobes_before", 64'(ns), 64'd10);
        chk("t3_strobes_after", 64'(late), 64'd0);
        chk("t3_no_latch", 64'(anyl), 64'd0);
        chk("t3_no_valid", 64'(anyv), 64'd0);

        // Response stalled 5 cycles with a pending request
        if0.rsp_ready_i = 1'b0;
        q0.push_back(24'h0F1E2D);
        start0(24'h0F1E2D);
        early = 0; unstable = 0; vc2 = 0;
        for (int c = 1; c <= 62; c++) begin
            if (c == 20) begin
                if0.req_valid_i = 1'b1;
                if0.req_data_i  = 24'h5A5A5A;
                q0.push_back(24'h5A5A5A);
            end
            if (c == 32) if0.rsp_ready_i = 1'b1;
            if (c == 34) if0.req_valid_i = 1'b0;
            @(negedge clk);
            if (c >= 20 && c <= 32 && if0.req_ready_o) early++;
            if (c >= 27 && c <= 32 && (!if0.rsp_valid_o || if0.rsp_data_o !== 24'h0F1E2D)) unstable++;
            if (c == 33) chk("t4_ready_c33", 64'(if0.req_ready_o), 64'd1);
            if (c == 34) chk("t4_strobe_c34", 64'(if0.sr_shift_en_o), 64'd1);
            if (c > 34 && if0.rsp_valid_o && vc2 == 0) vc2 = c;
            tick();
        end
        chk("t4_no_early_accept", 64'(early), 64'd0);
        chk("t4_rsp_stable", 64'(unstable), 64'd0);
        chk("t4_second_valid", 64'(vc2), 64'd60);

        // Asynchronous reset mid-shift, then a fresh transfer
        start0(24'hFFFFFF);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin
                #2 reset_ni = 1'b0;
                #1;
                chk("t5_shift_en", 64'(if0.sr_shift_en_o), 64'd0);
                chk("t5_din", 64'(if0.sr_din_o), 64'd0);
                chk("t5_busy", 64'(if0.busy_o), 64'd0);
                chk("t5_ready", 64'(if0.req_ready_o), 64'd1);
            end else begin
                @(negedge clk);
                tick();
            end
        end
        @(negedge clk) reset_ni = 1'b1;
        tick();
        q0.push_back(24'h3C3C3D);
        start0(24'h3C3C3D);
        obs0(30, ns, lc, vc, seq);
        chk("t5_strobes", 64'(ns), 64'd24);
        chk("t5_bit_order", 64'(seq), 64'(order24(24'h3C3C3D)));
        chk("t5_valid_cyc", 64'(vc), 64'd27);

        // Back-to-back requests with req_valid held high
        q0.push_back(24'h111111);
        if0.req_valid_i = 1'b1; if0.req_data_i = 24'h111111;
        @(negedge clk);
        tick();
        if0.req_data_i = 24'h222222;
        q0.push_back(24'h222222);
        ah = 0; rh = 0; vc2 = 0;
        for (int c = 1; c <= 60; c++) begin
            if (ah != 0) if0.req_valid_i = 1'b0;
            @(negedge clk);
            if (if0.rsp_valid_o && if0.rsp_ready_i && rh == 0) rh = c;
            if (if0.req_valid_i && if0.req_ready_o && ah == 0) ah = c;
            if (ah != 0 && c > ah && if0.rsp_valid_o && vc2 == 0) vc2 = c;
            tick();
        end
        chk("t6_first_rsp_hs", 64'(rh), 64'd27);
        chk("t6_second_req_hs", 64'(ah), 64'd28);
        chk("t6_second_valid", 64'(vc2), 64'd55);

        // Abort together with rsp_ready in RESP: not delivered
        start0(24'h00FF00);
        for (int c = 1; c <= 30; c++) begin
            if (c == 27) if0.abort_i = 1'b1;
            if (c == 28) if0.abort_i = 1'b0;
            @(negedge clk);
            if (c == 27) chk("t7_valid_c27", 64'(if0.rsp_valid_o), 64'd1);
            if (c == 28) begin
                chk("t7_valid_c28", 64'(if0.rsp_valid_o), 64'd0);
                chk("t7_ready_c28", 64'(if0.req_ready_o), 64'd1);
                chk("t7_data_kept", 64'(if0.rsp_data_o), 64'h00FF00);
            end
            tick();
        end

        // Abort in IDLE is ignored and the request is accepted
        if0.abort_i = 1'b1;
        q0.push_back(24'h0000C5);
        start0(24'h0000C5);
        if0.abort_i = 1'b0;
        obs0(30, ns, lc, vc, seq);
        chk("t8_strobes", 64'(ns), 64'd24);
        chk("t8_valid_cyc", 64'(vc), 64'd27);

        repeat (5) tick();
        chk("sb0_drained", 64'(q0.size()), 64'd0);
        chk("sb1_drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
